// File: rtl/ev_injector.sv
// EVG transmit-side event injector: queues software event codes and drops them
// into null low-byte slots of the outgoing stream through one register stage.
module ev_injector #(
  parameter int    FIFO_DEPTH = 16,
  parameter string DEBUG      = "false"
) (
  input  logic                          evgTxClk,
  input  logic                          evgReset,
  input  logic [15:0]                   evgTxDataIn,
  input  logic [1:0]                    evgTxCharIsKIn,
  output logic [15:0]                   evgTxDataOut,
  output logic [1:0]                    evgTxCharIsKOut,
  input  logic                          reqValid,
  input  logic [7:0]                    reqCode,
  output logic                          reqReady,
  input  logic                          injectEnable,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fillLevel,
  output logic [15:0]                   injectCount,
  output logic [7:0]                    rejectCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  (* mark_debug = DEBUG *) logic [7:0]  mem_q [FIFO_DEPTH];
  (* mark_debug = DEBUG *) logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [15:0]   inj_q, inj_d;
  logic [7:0]    rej_q, rej_d;
  logic [15:0]   dout_q, dout_d;
  logic [1:0]    kout_q;

  logic full, empty, accept, reserved, push, rej, free_slot, pop;

  // full comes from registered occupancy, so a same-cycle pop never frees room
  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign reqReady  = !full && !evgReset && !flush;
  assign accept    = reqValid && reqReady;
  assign reserved  = (reqCode == 8'h00) || (reqCode == 8'h70) || (reqCode == 8'h71);
  assign push      = accept && !reserved;
  assign rej       = accept && reserved;
  assign free_slot = !evgTxCharIsKIn[0] && (evgTxDataIn[7:0] == 8'h00);
  assign pop       = free_slot && !empty && injectEnable && !evgReset && !flush;

  always_comb begin
    dout_d = evgTxDataIn;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    inj_d  = inj_q;
    rej_d  = rej_q;
    if (pop) begin
      dout_d[7:0] = mem_q[rd_q];
      inj_d       = inj_q + 16'd1;
    end
    if (rej && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
    if (flush) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge evgTxClk) begin
    // stream stage runs through reset so the link never stalls
    dout_q <= dout_d;
    kout_q <= evgTxCharIsKIn;
    if (push) mem_q[wr_q] <= reqCode;
    if (evgReset) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      inj_q <= '0;
      rej_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      inj_q <= inj_d;
      rej_q <= rej_d;
    end
  end

  assign evgTxDataOut    = dout_q;
  assign evgTxCharIsKOut = kout_q;
  assign fillLevel       = cnt_q;
  assign injectCount     = inj_q;
  assign rejectCount     = rej_q;
endmodule

// File: tb/tb_ev_injector.sv
// Directed bench for ev_injector: hand-computed expectations on a 16-deep queue.
module tb_ev_injector;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [1:0]  kin;
  logic [15:0] dout;
  logic [1:0]  kout;
  logic        rv, rr, en, fl;
  logic [7:0]  code;
  logic [4:0]  fill;
  logic [15:0] icnt;
  logic [7:0]  rcnt;
  int checks = 0;
  int errors = 0;

  ev_injector #(.FIFO_DEPTH(16), .DEBUG("false")) dut (
    .evgTxClk(clk), .evgReset(rst), .evgTxDataIn(din), .evgTxCharIsKIn(kin),
    .evgTxDataOut(dout), .evgTxCharIsKOut(kout), .reqValid(rv), .reqCode(code),
    .reqReady(rr), .injectEnable(en), .flush(fl), .fillLevel(fill),
    .injectCount(icnt), .rejectCount(rcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; din = 16'h1234; kin = 2'b00; rv = 1'b0; code = 8'h00; en = 1'b1; fl = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(rr), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_icnt", 32'(icnt), 0);
    chk("rst_rcnt", 32'(rcnt), 0);
    chk("rst_pass", 32'(dout), 32'h1234);
    rst = 1'b0; din = 16'h0000; #1;
    chk("ready_after_rst", 32'(rr), 1);

    // two codes into an idle stream
    rv = 1'b1; code = 8'h2A; tick();
    code = 8'h2B; tick();
    chk("inj_2A", 32'(dout), 32'h002A);
    rv = 1'b0; tick();
    chk("inj_2B", 32'(dout), 32'h002B);
    chk("icnt_2", 32'(icnt), 2);
    chk("fill_0a", 32'(fill), 0);
    tick();
    chk("idle_null", 32'(dout), 32'h0000);

    // K characters are never free slots
    din = 16'h00BC; kin = 2'b01;
    rv = 1'b1; code = 8'h55; tick();
    rv = 1'b0; tick();
    chk("k_data", 32'(dout), 32'h00BC);
    chk("k_flag", 32'(kout), 32'h1);
    chk("k_fill", 32'(fill), 1);
    din = 16'h0000; kin = 2'b00; tick();
    chk("k_inj", 32'(dout), 32'h0055);
    chk("k_flag0", 32'(kout), 32'h0);
    chk("k_icnt", 32'(icnt), 3);

    // fill to full with injection disabled
    en = 1'b0; rv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      code = 8'(8'h10 + i); tick();
    end
    code = 8'h20; #1;
    chk("full_fill", 32'(fill), 16);
    chk("full_ready", 32'(rr), 0);
    tick();
    chk("full_hold", 32'(fill), 16);
    chk("full_pass", 32'(dout), 32'h0000);
    rv = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_order", 32'(dout), 32'(8'h10 + i));
    end
    chk("drain_fill", 32'(fill), 0);
    chk("drain_icnt", 32'(icnt), 19);

    // reserved codes are accepted and discarded
    rv = 1'b1; code = 8'h70; tick();
    chk("res70_out", 32'(dout), 0);
    code = 8'h71; tick();
    chk("res71_out", 32'(dout), 0);
    code = 8'h00; tick();
    chk("res00_out", 32'(dout), 0);
    chk("rcnt_3", 32'(rcnt), 3);
    chk("res_fill", 32'(fill), 0);
    code = 8'h70;
    for (int i = 0; i < 300; i++) tick();
    rv = 1'b0;
    chk("rcnt_sat", 32'(rcnt), 255);
    chk("res_icnt", 32'(icnt), 19);
    tick();
    chk("res_none", 32'(dout), 0);

    // reset in the middle of a drain
    en = 1'b0; rv = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      code = 8'(8'hA0 + i); tick();
    end
    rv = 1'b0; en = 1'b1;
    chk("mr_fill5", 32'(fill), 5);
    tick();
    chk("mr_A1", 32'(dout), 32'h00A1);
    tick();
    chk("mr_A2", 32'(dout), 32'h00A2);
    rst = 1'b1; din = 16'h5A00; #1;
    chk("mr_ready", 32'(rr), 0);
    tick();
    chk("mr_pass", 32'(dout), 32'h5A00);
    chk("mr_fill", 32'(fill), 0);
    chk("mr_icnt", 32'(icnt), 0);
    chk("mr_rcnt", 32'(rcnt), 0);
    rst = 1'b0; din = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_lost", 32'(dout), 0);
    end

    // flush with a request in flight
    en = 1'b0; rv = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      code = 8'(8'hB0 + i); tick();
    end
    chk("fl_fill4", 32'(fill), 4);
    code = 8'hB5; fl = 1'b1; #1;
    chk("fl_ready", 32'(rr), 0);
    tick();
    fl = 1'b0; rv = 1'b0;
    chk("fl_fill", 32'(fill), 0);
    chk("fl_icnt", 32'(icnt), 0);
    en = 1'b1;
    tick();
    chk("fl_empty1", 32'(dout), 0);
    tick();
    chk("fl_empty2", 32'(dout), 0);
    chk("fl_rcnt", 32'(rcnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
